// File: rtl/ascon_aead_sequencer_if.sv
// Bundle of the ASCON AEAD sequencer control, block-stream, tag and
// external-permutation signals. slave = sequencer view, master = host view.
interface ascon_aead_sequencer_if #(
  parameter int RATE = 64
);
  logic             start;
  logic             mode;
  logic             ad_present;
  logic [127:0]     key;
  logic [127:0]     nonce;
  logic [127:0]     tag_in;
  logic             in_valid;
  logic             in_ready;
  logic             in_ad;
  logic             in_last;
  logic [4:0]       in_len;
  logic [RATE-1:0]  in_data;
  logic             out_valid;
  logic [RATE-1:0]  out_data;
  logic [4:0]       out_len;
  logic [127:0]     tag;
  logic             tag_valid;
  logic             auth_ok;
  logic             err;
  logic             busy;
  logic [319:0]     perm_state;
  logic [7:0]       perm_rc;
  logic [319:0]     perm_next;

  modport slave (
    input  start, mode, ad_present, key, nonce, tag_in,
    input  in_valid, in_ad, in_last, in_len, in_data, perm_next,
    output in_ready, out_valid, out_data, out_len,
    output tag, tag_valid, auth_ok, err, busy, perm_state, perm_rc
  );

  modport master (
    output start, mode, ad_present, key, nonce, tag_in,
    output in_valid, in_ad, in_last, in_len, in_data, perm_next,
    input  in_ready, out_valid, out_data, out_len,
    input  tag, tag_valid, auth_ok, err, busy, perm_state, perm_rc
  );
endinterface

// File: rtl/ascon_aead_sequencer.sv
// ASCON AEAD mode sequencer: owns the 320-bit state and drives an external
// single-round permutation, one round per cycle.
// Optional feature macro ASCON_TAG_CHECK_EN: in decrypt, compare the computed
// tag with tag_in, report auth_ok and output a zero tag on mismatch.
// Without it auth_ok is tied low, tag_in is ignored and the tag is always shown.
module ascon_aead_sequencer #(
  parameter int A    = 12,
  parameter int B    = 6,
  parameter int RATE = 64
) (
  input  logic                  clk,
  input  logic                  nRST,
  ascon_aead_sequencer_if.slave bus
);
  localparam int RB   = RATE / 8;
  // lsb of the 128-bit window that absorbs the key before finalization
  localparam int KOFF = 320 - RATE - 128;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INIT      = 3'd1;
  localparam logic [2:0] ST_AD_WAIT   = 3'd2;
  localparam logic [2:0] ST_AD_PERM   = 3'd3;
  localparam logic [2:0] ST_DATA_WAIT = 3'd4;
  localparam logic [2:0] ST_DATA_PERM = 3'd5;
  localparam logic [2:0] ST_FINAL     = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  logic [2:0]      r_state;
  logic [319:0]    r_S;
  logic [3:0]      r_rnd;
  logic            r_mode;
  logic            r_adp;
  logic            r_ad_last;
  logic [127:0]    r_key;
  logic            r_out_valid;
  logic [RATE-1:0] r_out_data;
  logic [4:0]      r_out_len;
  logic [127:0]    r_tag;
  logic            r_tag_valid;
  logic            r_auth_ok;
  logic            r_err;

  logic            w_perm;
  logic [4:0]      w_n;
  logic [3:0]      w_rnum;
  logic            w_last_rnd;
  logic            w_wait;
  logic            w_err;
  logic [RATE-1:0] w_sr;
  logic [RATE-1:0] w_blk;
  logic [319:0]    w_s_acc;
  logic [127:0]    w_tag_calc;

`ifdef ASCON_TAG_CHECK_EN
  logic [127:0]    r_tag_in;
  logic            w_match;
  assign w_match = (w_tag_calc == r_tag_in);
`else
  logic            w_unused_tag_in;
  assign w_unused_tag_in = ^bus.tag_in;
`endif

  // Keep bytes 0..len-1, put 0x80 at byte len, zero the rest (len = RB: no pad byte)
  function automatic logic [RATE-1:0] pad_blk(input logic [RATE-1:0] d, input logic [4:0] len);
    logic [RATE-1:0] p;
    p = '0;
    for (int i = 0; i < RB; i++) begin
      if (i < int'(len))       p[RATE-1-8*i -: 8] = d[RATE-1-8*i -: 8];
      else if (i == int'(len)) p[RATE-1-8*i -: 8] = 8'h80;
    end
    return p;
  endfunction

  // Keep bytes 0..len-1 and zero the rest
  function automatic logic [RATE-1:0] mask_blk(input logic [RATE-1:0] d, input logic [4:0] len);
    logic [RATE-1:0] m;
    m = '0;
    for (int i = 0; i < RB; i++) begin
      if (i < int'(len)) m[RATE-1-8*i -: 8] = d[RATE-1-8*i -: 8];
    end
    return m;
  endfunction

  // Round control: p^n round k uses r = 12-n+k
  assign w_perm     = (r_state == ST_INIT) || (r_state == ST_AD_PERM) ||
                      (r_state == ST_DATA_PERM) || (r_state == ST_FINAL);
  assign w_n        = ((r_state == ST_INIT) || (r_state == ST_FINAL)) ? 5'(A) : 5'(B);
  assign w_rnum     = 4'(5'd12 - w_n + {1'b0, r_rnd});
  assign w_last_rnd = ({1'b0, r_rnd} == (w_n - 5'd1));
  assign w_tag_calc = bus.perm_next[127:0] ^ r_key;

  assign w_wait = (r_state == ST_AD_WAIT) || (r_state == ST_DATA_WAIT);
  assign w_err  = (bus.in_len > 5'(RB)) ||
                  (bus.in_last && (bus.in_len == 5'(RB))) ||
                  ((r_state == ST_DATA_WAIT) && bus.in_ad) ||
                  ((r_state == ST_AD_WAIT) && !bus.in_ad);

  assign bus.in_ready   = w_wait;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.perm_state = r_S;
  assign bus.perm_rc    = w_perm ? {4'hF - w_rnum, w_rnum} : 8'h00;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_len    = r_out_len;
  assign bus.tag        = r_tag;
  assign bus.tag_valid  = r_tag_valid;
  assign bus.auth_ok    = r_auth_ok;
  assign bus.err        = r_err;

  // Absorb/squeeze of the presented block: output block and next state
  always_comb begin
    w_sr    = r_S[319 -: RATE];
    w_blk   = mask_blk(w_sr ^ bus.in_data, bus.in_len);
    w_s_acc = r_S;
    if ((r_state == ST_AD_WAIT) || !r_mode)
      w_s_acc[319 -: RATE] = w_sr ^ pad_blk(bus.in_data, bus.in_len);
    else if (bus.in_last)
      w_s_acc[319 -: RATE] = w_sr ^ pad_blk(w_blk, bus.in_len);
    else
      w_s_acc[319 -: RATE] = bus.in_data;
    if ((r_state == ST_DATA_WAIT) && bus.in_last)
      w_s_acc[KOFF +: 128] = w_s_acc[KOFF +: 128] ^ r_key;
  end

  // Sequencer FSM, permutation state and registered outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_S         <= '0;
      r_rnd       <= '0;
      r_mode      <= 1'b0;
      r_adp       <= 1'b0;
      r_ad_last   <= 1'b0;
      r_key       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_len   <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_err       <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      r_tag_in    <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_tag_valid <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_S     <= {8'd128, 8'(RATE), 8'(A), 8'(B), 32'h0, bus.key, bus.nonce};
            r_key   <= bus.key;
            r_mode  <= bus.mode;
            r_adp   <= bus.ad_present;
            r_tag   <= '0;
            r_rnd   <= '0;
            r_state <= ST_INIT;
`ifdef ASCON_TAG_CHECK_EN
            r_tag_in <= bus.tag_in;
`endif
          end
        end
        ST_INIT: begin
          r_S   <= bus.perm_next;
          r_rnd <= r_rnd + 4'd1;
          if (w_last_rnd) begin
            r_rnd   <= '0;
            r_S     <= bus.perm_next ^ {192'h0, r_key} ^ {319'h0, !r_adp};
            r_state <= r_adp ? ST_AD_WAIT : ST_DATA_WAIT;
          end
        end
        ST_AD_WAIT, ST_DATA_WAIT: begin
          if (bus.in_valid) begin
            if (w_err) begin
              r_err   <= 1'b1;
              r_S     <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_S <= w_s_acc;
              if (r_state == ST_AD_WAIT) begin
                r_ad_last <= bus.in_last;
                r_state   <= ST_AD_PERM;
              end else begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_blk;
                r_out_len   <= bus.in_len;
                r_state     <= bus.in_last ? ST_FINAL : ST_DATA_PERM;
              end
            end
          end
        end
        ST_AD_PERM: begin
          r_S   <= bus.perm_next;
          r_rnd <= r_rnd + 4'd1;
          if (w_last_rnd) begin
            r_rnd   <= '0;
            r_S     <= bus.perm_next ^ {319'h0, r_ad_last};
            r_state <= r_ad_last ? ST_DATA_WAIT : ST_AD_WAIT;
          end
        end
        ST_DATA_PERM: begin
          r_S   <= bus.perm_next;
          r_rnd <= r_rnd + 4'd1;
          if (w_last_rnd) begin
            r_rnd   <= '0;
            r_state <= ST_DATA_WAIT;
          end
        end
        ST_FINAL: begin
          r_S   <= bus.perm_next;
          r_rnd <= r_rnd + 4'd1;
          if (w_last_rnd) begin
            r_rnd       <= '0;
            r_tag_valid <= 1'b1;
            r_state     <= ST_DONE;
`ifdef ASCON_TAG_CHECK_EN
            r_auth_ok   <= r_mode && w_match;
            r_tag       <= (r_mode && !w_match) ? '0 : w_tag_calc;
`else
            r_tag       <= w_tag_calc;
`endif
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Directed bench for ascon_aead_sequencer: a RATE=64 and a RATE=128 instance,
// each closed around a behavioural ASCON round.
module tb_ascon_aead_sequencer;
  localparam logic [127:0] KN     = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT64  = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [127:0] KAT128 = 128'h7A834E6F09210957067B10FD831F0078;
`ifdef ASCON_TAG_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  int   t_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_aead_sequencer_if #(.RATE(64))  b64 ();
  ascon_aead_sequencer_if #(.RATE(128)) b128 ();

  ascon_aead_sequencer #(.A(12), .B(6), .RATE(64))  u64  (.clk(clk), .nRST(nRST), .bus(b64));
  ascon_aead_sequencer #(.A(12), .B(8), .RATE(128)) u128 (.clk(clk), .nRST(nRST), .bus(b128));

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, rc};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = x0 ^ (~x1 & x2);
    t1 = x1 ^ (~x2 & x3);
    t2 = x2 ^ (~x3 & x4);
    t3 = x3 ^ (~x4 & x0);
    t4 = x4 ^ (~x0 & x1);
    t1 = t1 ^ t0; t0 = t0 ^ t4; t3 = t3 ^ t2; t2 = ~t2;
    x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
    x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
    x2 = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
    x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
    x4 = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign b64.perm_next  = ascon_round(b64.perm_state, b64.perm_rc);
  assign b128.perm_next = ascon_round(b128.perm_state, b128.perm_rc);

  task automatic chk(input string nm, input logic [319:0] obs, input logic [319:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic start64(input logic m, input logic adp, input logic [127:0] tin);
    @(negedge clk);
    b64.key = KN; b64.nonce = KN; b64.mode = m; b64.ad_present = adp;
    b64.tag_in = tin; b64.start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    b64.start = 1'b0;
  endtask

  task automatic send64(input logic ad, input logic last, input logic [4:0] len,
                        input logic [63:0] d, output logic ov, output logic [63:0] od,
                        output logic [4:0] ol, output logic er, output logic bz);
    int n = 0;
    while (!b64.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", 320'(n < 100), 320'(1));
    b64.in_valid = 1'b1; b64.in_ad = ad; b64.in_last = last; b64.in_len = len; b64.in_data = d;
    @(negedge clk);
    b64.in_valid = 1'b0;
    ov = b64.out_valid; od = b64.out_data; ol = b64.out_len; er = b64.err; bz = b64.busy;
  endtask

  task automatic wait_tag64(output logic [127:0] t, output logic a, output int lat);
    int n = 0;
    while (!b64.tag_valid && n < 300) begin @(negedge clk); n++; end
    chk("tag_wait", 320'(n < 300), 320'(1));
    t = b64.tag; a = b64.auth_ok; lat = cyc - t_start + 1;
    @(negedge clk);
    chk("tag_pulse_1cyc", 320'(b64.tag_valid), 320'(0));
  endtask

  // Empty AD, one last len-0 message block; checks output block, tag, auth, latency
  task automatic kat64(input string nm, input logic m, input logic [127:0] tin,
                       input logic [127:0] etag, input logic eauth);
    logic ov, er, bz, a;
    logic [63:0] od;
    logic [4:0] ol;
    logic [127:0] t;
    int lat;
    start64(m, 1'b0, tin);
    chk({nm, "_busy"}, 320'(b64.busy), 320'(1));
    chk({nm, "_rc0"}, 320'(b64.perm_rc), 320'(8'hF0));
    send64(1'b0, 1'b1, 5'd0, 64'h0, ov, od, ol, er, bz);
    chk({nm, "_ov"}, 320'(ov), 320'(1));
    chk({nm, "_od"}, 320'(od), 320'(0));
    wait_tag64(t, a, lat);
    chk({nm, "_tag"}, 320'(t), 320'(etag));
    chk({nm, "_auth"}, 320'(a), 320'(eauth));
    chk({nm, "_lat"}, 320'(lat), 320'(2 * 12 + 3));
  endtask

  task automatic kat128();
    int n = 0;
    @(negedge clk);
    b128.key = KN; b128.nonce = KN; b128.mode = 1'b0; b128.ad_present = 1'b0;
    b128.tag_in = '0; b128.start = 1'b1;
    @(negedge clk);
    b128.start = 1'b0;
    while (!b128.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("r128_ready_wait", 320'(n < 100), 320'(1));
    b128.in_valid = 1'b1; b128.in_ad = 1'b0; b128.in_last = 1'b1; b128.in_len = 5'd0; b128.in_data = '0;
    @(negedge clk);
    b128.in_valid = 1'b0;
    chk("r128_ov", 320'(b128.out_valid), 320'(1));
    n = 0;
    while (!b128.tag_valid && n < 300) begin @(negedge clk); n++; end
    chk("r128_tag_wait", 320'(n < 300), 320'(1));
    chk("r128_tag", 320'(b128.tag), 320'(KAT128));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ov, er, bz, a;
    logic [63:0] od, ct0, ct1;
    logic [4:0] ol;
    logic [127:0] etag, t;
    int lat, cnt;

    b64.start = 0; b64.mode = 0; b64.ad_present = 0; b64.key = '0; b64.nonce = '0; b64.tag_in = '0;
    b64.in_valid = 0; b64.in_ad = 0; b64.in_last = 0; b64.in_len = '0; b64.in_data = '0;
    b128.start = 0; b128.mode = 0; b128.ad_present = 0; b128.key = '0; b128.nonce = '0; b128.tag_in = '0;
    b128.in_valid = 0; b128.in_ad = 0; b128.in_last = 0; b128.in_len = '0; b128.in_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 320'(b64.busy), 320'(0));
    chk("rst_ready", 320'(b64.in_ready), 320'(0));
    chk("rst_tag", 320'(b64.tag), 320'(0));
    chk("rst_tag_valid", 320'(b64.tag_valid), 320'(0));
    chk("rst_out_valid", 320'(b64.out_valid), 320'(0));
    chk("rst_state", b64.perm_state, 320'(0));
    chk("rst_rc", 320'(b64.perm_rc), 320'(0));
    chk("rst_err", 320'(b64.err), 320'(0));
    nRST = 1'b1;

    // known-answer tags, both rates
    kat64("kat64", 1'b0, '0, KAT64, 1'b0);
    kat128();

    // decrypt of the empty message: matching and corrupted tag_in
    kat64("dec_ok", 1'b1, KAT64, KAT64, CHK);
    kat64("dec_bad", 1'b1, KAT64 ^ 128'h1, CHK ? 128'h0 : KAT64, 1'b0);

    // start while busy is ignored; later key change does not matter
    start64(1'b0, 1'b0, '0);
    b64.key = ~KN; b64.start = 1'b1;
    repeat (3) @(negedge clk);
    b64.start = 1'b0; b64.key = KN;
    send64(1'b0, 1'b1, 5'd0, 64'h0, ov, od, ol, er, bz);
    wait_tag64(t, a, lat);
    chk("ign_start_tag", 320'(t), 320'(KAT64));

    // encrypt with one full AD block + len-0 AD terminator, two message blocks
    start64(1'b0, 1'b1, '0);
    send64(1'b1, 1'b0, 5'd8, 64'h4144303132333435, ov, od, ol, er, bz);
    chk("enc_ad0_err", 320'(er), 320'(0));
    send64(1'b1, 1'b1, 5'd0, 64'h0, ov, od, ol, er, bz);
    send64(1'b0, 1'b0, 5'd8, 64'h0011223344556677, ov, ct0, ol, er, bz);
    chk("enc_m0_ov", 320'(ov), 320'(1));
    chk("enc_m0_len", 320'(ol), 320'(8));
    send64(1'b0, 1'b1, 5'd3, 64'hA1B2C3FFFFFFFFFF, ov, ct1, ol, er, bz);
    chk("enc_m1_len", 320'(ol), 320'(3));
    chk("enc_m1_zero_tail", 320'(ct1[39:0]), 320'(0));
    wait_tag64(etag, a, lat);
    chk("enc_auth", 320'(a), 320'(0));

    // decrypt the ciphertext back
    start64(1'b1, 1'b1, etag);
    send64(1'b1, 1'b0, 5'd8, 64'h4144303132333435, ov, od, ol, er, bz);
    send64(1'b1, 1'b1, 5'd0, 64'h0, ov, od, ol, er, bz);
    send64(1'b0, 1'b0, 5'd8, ct0, ov, od, ol, er, bz);
    chk("dec_m0_pt", 320'(od), 320'(64'h0011223344556677));
    send64(1'b0, 1'b1, 5'd3, ct1, ov, od, ol, er, bz);
    chk("dec_m1_pt", 320'(od), 320'(64'hA1B2C30000000000));
    wait_tag64(t, a, lat);
    chk("rt_auth", 320'(a), 320'(CHK));
    chk("rt_tag", 320'(t), 320'(etag));

    // protocol errors
    start64(1'b0, 1'b0, '0);
    send64(1'b0, 1'b1, 5'd8, 64'hFFFFFFFFFFFFFFFF, ov, od, ol, er, bz);
    chk("err_lastfull", 320'(er), 320'(1));
    chk("err_lastfull_busy", 320'(bz), 320'(0));
    chk("err_lastfull_ov", 320'(ov), 320'(0));
    chk("err_lastfull_state", b64.perm_state, 320'(0));
    @(negedge clk);
    chk("err_pulse_1cyc", 320'(b64.err), 320'(0));
    start64(1'b0, 1'b0, '0);
    send64(1'b1, 1'b1, 5'd1, 64'h0, ov, od, ol, er, bz);
    chk("err_ad_in_data", 320'(er), 320'(1));
    start64(1'b0, 1'b1, '0);
    send64(1'b0, 1'b1, 5'd1, 64'h0, ov, od, ol, er, bz);
    chk("err_msg_in_ad", 320'(er), 320'(1));
    start64(1'b0, 1'b0, '0);
    send64(1'b0, 1'b0, 5'd9, 64'h0, ov, od, ol, er, bz);
    chk("err_len_big", 320'(er), 320'(1));
    chk("err_len_big_busy", 320'(bz), 320'(0));
    kat64("after_err", 1'b0, '0, KAT64, 1'b0);

    // reset during FINAL
    start64(1'b0, 1'b0, '0);
    send64(1'b0, 1'b1, 5'd0, 64'h0, ov, od, ol, er, bz);
    repeat (4) @(negedge clk);
    chk("final_busy", 320'(b64.busy), 320'(1));
    #2 nRST = 1'b0;
    #1;
    chk("rstmid_busy", 320'(b64.busy), 320'(0));
    chk("rstmid_state", b64.perm_state, 320'(0));
    chk("rstmid_rc", 320'(b64.perm_rc), 320'(0));
    chk("rstmid_tag", 320'(b64.tag), 320'(0));
    chk("rstmid_tag_valid", 320'(b64.tag_valid), 320'(0));
    chk("rstmid_out_valid", 320'(b64.out_valid), 320'(0));
    @(negedge clk);
    nRST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b64.tag_valid || b64.out_valid) cnt++;
    end
    chk("rstmid_no_strobes", 320'(cnt), 320'(0));
    kat64("after_rst", 1'b0, '0, KAT64, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
